// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, start-bit validation at half a bit,
// mid-bit sampling of 8 data bits (LSB first) and stop-bit check with framing-error strobe.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Frame_Err
);

   localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_e;

   state_e           state_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic [CNT_W-1:0] clk_cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;

   // Synchronizer resets to idle-high so reset release never looks like a start bit.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_Rx_Serial;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Counter value k-1 at the k-th edge of a phase, so decisions fire on the HALF-th / CLKS_PER_BIT-th edge.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= S_IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         o_Rx_DV     <= 1'b0;
         o_Rx_Byte   <= 8'h00;
         o_Rx_Active <= 1'b0;
         o_Frame_Err <= 1'b0;
      end else begin
         o_Rx_DV     <= 1'b0;
         o_Frame_Err <= 1'b0;
         case (state_q)
            S_IDLE: begin
               clk_cnt_q <= '0;
               bit_idx_q <= '0;
               if (!rx_s_q) begin
                  state_q     <= S_START;
                  o_Rx_Active <= 1'b1;
               end
            end
            S_START: begin
               if (clk_cnt_q == HALF_LAST) begin
                  clk_cnt_q <= '0;
                  if (!rx_s_q) begin
                     bit_idx_q <= '0;
                     state_q   <= S_DATA;
                  end else begin
                     state_q     <= S_IDLE;
                     o_Rx_Active <= 1'b0;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            S_DATA: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q          <= '0;
                  shift_q[bit_idx_q] <= rx_s_q;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            S_STOP: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q   <= '0;
                  o_Rx_Active <= 1'b0;
                  if (rx_s_q) begin
                     o_Rx_Byte <= shift_q;
                     o_Rx_DV   <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     o_Frame_Err <= 1'b1;
                     state_q     <= S_BREAK;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            S_BREAK: begin
               if (rx_s_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               o_Rx_Active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames; all strobes are compared against
// an event-level decoder that replays the recorded line/reset history with the sampling-time rules.
module tb_uart_rx;

   localparam int CPB  = 10;
   localparam int HALF = (CPB - 1) / 2;
   localparam int MAXC = 20000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_line;
   logic       dv;
   logic [7:0] rx_byte;
   logic       active;
   logic       ferr;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Rx_Serial (rx_line),
      .o_Rx_DV     (dv),
      .o_Rx_Byte   (rx_byte),
      .o_Rx_Active (active),
      .o_Frame_Err (ferr)
   );

   always #5 clk = ~clk;

   // Line and reset level seen at every rising edge, indexed by edge number.
   int   cyc = 0;
   logic hist_l [MAXC];
   logic hist_r [MAXC];
   always @(posedge clk) begin
      if (cyc < MAXC) begin
         hist_l[cyc] = rx_line;
         hist_r[cyc] = rst_n;
      end
      cyc = cyc + 1;
   end

   // Observed strobes, tagged with the edge that produced them.
   int         dv_t [$];
   logic [7:0] dv_b [$];
   int         err_t [$];
   int         both_cnt   = 0;
   int         active_cyc = 0;
   always @(negedge clk) begin
      if (dv) begin
         dv_t.push_back(cyc - 1);
         dv_b.push_back(rx_byte);
      end
      if (ferr) err_t.push_back(cyc - 1);
      if (dv && ferr) both_cnt++;
      if (active) active_cyc++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int p, input logic stop_v);
      rx_line = 1'b0;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(p);
      end
      rx_line = stop_v;
      tick(p);
   endtask

   // Level the receiver logic acts on at edge e: pin value two edges earlier, idle while reset is near.
   function automatic logic r_at(input int e);
      if (e < 2) return 1'b1;
      if (!hist_r[e] || !hist_r[e-1] || !hist_r[e-2]) return 1'b1;
      return hist_l[e-2];
   endfunction

   function automatic int first_rst(input int a, input int b);
      for (int i = a; i <= b; i++) if (!hist_r[i]) return i;
      return -1;
   endfunction

   int         exp_dv_t [$];
   logic [7:0] exp_dv_b [$];
   int         exp_err_t [$];

   task automatic run_model(input int last);
      int         e, t0, g, s, fr, b;
      logic [7:0] by;
      e = 0;
      while (e <= last) begin
         if (!hist_r[e] || r_at(e)) begin
            e++;
            continue;
         end
         t0 = e;
         g  = t0 + HALF;
         s  = g + 9 * CPB;
         if (s > last) break;
         fr = first_rst(t0 + 1, g);
         if (fr >= 0) begin
            e = fr;
            continue;
         end
         if (r_at(g)) begin
            e = g + 1;
            continue;
         end
         fr = first_rst(g + 1, s);
         if (fr >= 0) begin
            e = fr;
            continue;
         end
         for (int n = 0; n < 8; n++) by[n] = r_at(g + (n + 1) * CPB);
         if (r_at(s)) begin
            exp_dv_t.push_back(s);
            exp_dv_b.push_back(by);
            e = s + 1;
         end else begin
            exp_err_t.push_back(s);
            b = s + 1;
            while (b <= last && hist_r[b] && !r_at(b)) b++;
            e = (b <= last && !hist_r[b]) ? b : b + 1;
         end
      end
   endtask

   initial begin
      int         n0, e0, a0, gl, gap, nmin;
      logic [7:0] rb;

      rst_n   = 1'b0;
      rx_line = 1'b1;
      tick(3);
      check("rst_dv", 32'(dv), 32'd0);
      check("rst_byte", 32'(rx_byte), 32'h00);
      check("rst_active", 32'(active), 32'd0);
      check("rst_err", 32'(ferr), 32'd0);
      rst_n = 1'b1;
      tick(5);

      // Single frame: one strobe, active for exactly start-detect to stop-sample.
      n0 = dv_t.size(); e0 = err_t.size(); a0 = active_cyc;
      send(8'hA5, CPB, 1'b1);
      tick(20);
      check("a5_dv_count", 32'(dv_t.size() - n0), 32'd1);
      if (dv_t.size() > n0) check("a5_byte", 32'(dv_b[n0]), 32'hA5);
      check("a5_err_count", 32'(err_t.size() - e0), 32'd0);
      check("a5_active_cycles", 32'(active_cyc - a0), 32'(HALF + 9 * CPB));
      check("a5_active_after", 32'(active), 32'd0);

      // Back-to-back frames with no idle gap.
      n0 = dv_t.size(); e0 = err_t.size();
      send(8'h00, CPB, 1'b1);
      send(8'hFF, CPB, 1'b1);
      tick(20);
      check("b2b_dv_count", 32'(dv_t.size() - n0), 32'd2);
      if (dv_t.size() > n0 + 1) begin
         check("b2b_byte0", 32'(dv_b[n0]), 32'h00);
         check("b2b_byte1", 32'(dv_b[n0+1]), 32'hFF);
         check("b2b_spacing", 32'(dv_t[n0+1] - dv_t[n0]), 32'(10 * CPB));
      end
      check("b2b_err_count", 32'(err_t.size() - e0), 32'd0);

      // Short low glitch is rejected, next frame still decodes.
      n0 = dv_t.size(); e0 = err_t.size();
      rx_line = 1'b0;
      tick(3);
      rx_line = 1'b1;
      check("glitch_active_on", 32'(active), 32'd1);
      tick(12);
      check("glitch_active_off", 32'(active), 32'd0);
      check("glitch_dv_count", 32'(dv_t.size() - n0), 32'd0);
      check("glitch_err_count", 32'(err_t.size() - e0), 32'd0);
      send(8'h3C, CPB, 1'b1);
      tick(20);
      check("post_glitch_byte", 32'(rx_byte), 32'h3C);
      check("post_glitch_dv_count", 32'(dv_t.size() - n0), 32'd1);

      // Stop bit low followed by a long break.
      n0 = dv_t.size(); e0 = err_t.size();
      send(8'h5A, CPB, 1'b0);
      tick(30 * CPB);
      check("brk_err_count", 32'(err_t.size() - e0), 32'd1);
      check("brk_dv_count", 32'(dv_t.size() - n0), 32'd0);
      check("brk_byte_kept", 32'(rx_byte), 32'h3C);
      check("brk_active", 32'(active), 32'd0);
      rx_line = 1'b1;
      tick(20);
      check("brk_err_after_high", 32'(err_t.size() - e0), 32'd1);
      check("brk_dv_after_high", 32'(dv_t.size() - n0), 32'd0);

      // Reset in the middle of data bit 4 of 8'hC3.
      n0 = dv_t.size(); e0 = err_t.size();
      rb = 8'hC3;
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_line = rb[i];
         tick(CPB);
      end
      rx_line = rb[4];
      tick(CPB / 2);
      rst_n = 1'b0;
      #1;
      check("midrst_dv", 32'(dv), 32'd0);
      check("midrst_byte", 32'(rx_byte), 32'h00);
      check("midrst_active", 32'(active), 32'd0);
      check("midrst_err", 32'(ferr), 32'd0);
      rx_line = 1'b1;
      tick(5);
      rst_n = 1'b1;
      tick(5);
      send(8'h81, CPB, 1'b1);
      tick(20);
      check("post_rst_dv_count", 32'(dv_t.size() - n0), 32'd1);
      check("post_rst_byte", 32'(rx_byte), 32'h81);
      check("post_rst_err_count", 32'(err_t.size() - e0), 32'd0);

      // Bit-period mismatch; outcome judged by the decoder model.
      send(8'h96, CPB + 1, 1'b1);
      tick(30);
      send(8'h96, CPB - 1, 1'b1);
      tick(30);

      // Random frames with optional short glitches and random idle gaps.
      for (int k = 0; k < 16; k++) begin
         rb  = 8'($urandom);
         gap = int'($urandom_range(0, 12));
         n0 = dv_t.size(); e0 = err_t.size();
         if ($urandom_range(0, 3) == 0) begin
            gl = int'($urandom_range(1, 4));
            rx_line = 1'b0;
            tick(gl);
            rx_line = 1'b1;
            tick(12);
         end
         send(rb, CPB, 1'b1);
         tick(gap);
         tick(2);
         check($sformatf("rand%0d_dv_count", k), 32'(dv_t.size() - n0), 32'd1);
         check($sformatf("rand%0d_byte", k), 32'(rx_byte), 32'(rb));
         check($sformatf("rand%0d_err_count", k), 32'(err_t.size() - e0), 32'd0);
      end
      rx_line = 1'b1;
      tick(20);

      // Whole-run comparison against the decoder model.
      run_model(cyc - 1);
      check("model_dv_count", 32'(dv_t.size()), 32'(exp_dv_t.size()));
      nmin = (dv_t.size() < exp_dv_t.size()) ? dv_t.size() : exp_dv_t.size();
      for (int i = 0; i < nmin; i++) begin
         check($sformatf("model_dv_edge%0d", i), 32'(dv_t[i]), 32'(exp_dv_t[i]));
         check($sformatf("model_dv_byte%0d", i), 32'(dv_b[i]), 32'(exp_dv_b[i]));
      end
      check("model_err_count", 32'(err_t.size()), 32'(exp_err_t.size()));
      nmin = (err_t.size() < exp_err_t.size()) ? err_t.size() : exp_err_t.size();
      for (int i = 0; i < nmin; i++) begin
         check($sformatf("model_err_edge%0d", i), 32'(err_t[i]), 32'(exp_err_t[i]));
      end
      check("dv_err_overlap", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
